// File: rtl/fmac_pkg.sv
// Shared definitions for the fmac_ws array: PE mode encodings and sequencer states.
package fmac_pkg;

  localparam logic [2:0] MODE_FWD = 3'b001;
  localparam logic [2:0] MODE_BWD = 3'b010;
  localparam logic [2:0] MODE_ACC = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStream,
    StDrain,
    StDone
  } seq_state_e;

  function automatic logic mode_legal(logic [2:0] mode);
    return mode inside {MODE_FWD, MODE_BWD, MODE_ACC};
  endfunction

endpackage

// File: rtl/fmac_ws_seq_if.sv
// Command handshake between a host and the fmac_ws_seq sequencer.
interface fmac_ws_seq_if #(
  parameter int unsigned CNTW = 16
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_mode;
  logic [CNTW-1:0] cmd_len;
  logic            cmd_preload;

  modport master (
    output cmd_valid, cmd_mode, cmd_len, cmd_preload,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len, cmd_preload,
    output cmd_ready
  );

endinterface

// File: rtl/fmac_valid_delay.sv
// Fixed-depth shift register delaying a strobe, with synchronous clear.
module fmac_valid_delay #(
  parameter int unsigned DEPTH = 7
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_in,
  output logic o_out
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sr_q <= '0;
    end else if (i_clear) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | DEPTH'(i_in);
    end
  end

  assign o_out = sr_q[DEPTH-1];

endmodule

// File: rtl/fmac_ws_seq.sv
// Command sequencer for a weight-stationary fmac_ws systolic array: preload, stream, drain.
module fmac_ws_seq
  import fmac_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  fmac_ws_seq_if.slave cmd,
  input  logic         i_abort,
  output logic [2:0]   o_mode,
  output logic         o_pre_store,
  output logic         o_sel_diagonal,
  output logic         o_wfeed_en,
  output logic         o_feed_en,
  output logic         o_out_valid,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  localparam int unsigned D = ROWS + COLS - 1;
  localparam logic [CNTW-1:0] CntOne = CNTW'(1);

  seq_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] len_q, len_d;
  logic [2:0]      mode_q, mode_d;
  logic            err_d;
  logic            cmd_ready_q, busy_q, done_q, err_q;
  logic            pre_store_q, sel_diag_q, wfeed_q, feed_q;
  logic            abort_act;

  assign abort_act = i_abort && (state_q inside {StLoad, StStream, StDrain});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          if (!mode_legal(cmd.cmd_mode) || cmd.cmd_len == '0) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            mode_d = cmd.cmd_mode;
            len_d  = cmd.cmd_len;
            if (cmd.cmd_preload) begin
              state_d = StLoad;
              cnt_d   = CNTW'(ROWS);
            end else begin
              state_d = StStream;
              cnt_d   = cmd.cmd_len;
            end
          end
        end
      end
      StLoad: begin
        if (abort_act) begin
          state_d = StIdle;
        end else if (cnt_q == CntOne) begin
          state_d = StStream;
          cnt_d   = len_q;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StStream: begin
        if (abort_act) begin
          state_d = StIdle;
        end else if (cnt_q == CntOne) begin
          state_d = StDrain;
          cnt_d   = CNTW'(D);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDrain: begin
        if (abort_act) begin
          state_d = StIdle;
        end else if (cnt_q == CntOne) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      mode_q      <= MODE_FWD;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pre_store_q <= 1'b0;
      sel_diag_q  <= 1'b0;
      wfeed_q     <= 1'b0;
      feed_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      cmd_ready_q <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      err_q       <= err_d;
      pre_store_q <= (state_d == StLoad) && (cnt_d == CntOne);
      wfeed_q     <= (state_d == StLoad);
      feed_q      <= (state_d == StStream);
      // First accumulate STREAM cycle starts from the local fp, later cycles chain diagonally.
      sel_diag_q  <= (mode_d == MODE_ACC) &&
                     (((state_d == StStream) && (state_q == StStream)) || (state_d == StDrain));
    end
  end

  fmac_valid_delay #(
    .DEPTH (D)
  ) u_valid_delay (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (abort_act),
    .i_in      (feed_q),
    .o_out     (o_out_valid)
  );

  assign cmd.cmd_ready  = cmd_ready_q;
  assign o_mode         = mode_q;
  assign o_pre_store    = pre_store_q;
  assign o_sel_diagonal = sel_diag_q;
  assign o_wfeed_en     = wfeed_q;
  assign o_feed_en      = feed_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

endmodule
